// File: rtl/serial_compare_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// Module      : serial_cmp_pkg
// Description : Shared constants for the serial compare scheduler: FSM state
//               encoding, comparator state encoding and the round-robin pick.
// Revision    : 1.0 - initial release
// ============================================================================
package serial_cmp_pkg;

  // Scheduler FSM states
  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_SHIFT = 2'b01;
  localparam logic [1:0] ST_DONE  = 2'b10;

  // Bit-serial comparator states
  localparam logic [1:0] CMP_EQ = 2'b00;
  localparam logic [1:0] CMP_GT = 2'b01;
  localparam logic [1:0] CMP_LT = 2'b10;

  // Winner index: a lone request wins outright; on a tie the requester that
  // was not served last wins.
  function automatic logic rr_pick(input logic [1:0] req, input logic last);
    return (req == 2'b11) ? ~last : req[1];
  endfunction

endpackage
`default_nettype wire

// File: rtl/serial_compare_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module      : serial_compare_scheduler_if
// Description : Requester-side bundle of the serial compare scheduler:
//               requests, operand pairs, grant/status and result flags.
// Revision    : 1.0 - initial release
// ============================================================================
interface serial_compare_scheduler_if #(
  parameter int WIDTH = 8
);
  logic [1:0]       req;
  logic [WIDTH-1:0] a0;
  logic [WIDTH-1:0] b0;
  logic [WIDTH-1:0] a1;
  logic [WIDTH-1:0] b1;
  logic [1:0]       gnt;
  logic             busy;
  logic             done;
  logic             done_id;
  logic             L;
  logic             E;
  logic             G;

  // Operand producers
  modport master (
    output req, a0, b0, a1, b1,
    input  gnt, busy, done, done_id, L, E, G
  );

  // The scheduler itself
  modport slave (
    input  req, a0, b0, a1, b1,
    output gnt, busy, done, done_id, L, E, G
  );
endinterface
`default_nettype wire

// File: rtl/serial_compare_scheduler_cmp.sv
`default_nettype none
// ============================================================================
// Module      : bit_serial_comparator
// Description : MSB-first unsigned bit-serial comparator. Starts at EQ; the
//               first differing bit decides GT/LT, which then stays sticky
//               until clr.
// Revision    : 1.0 - initial release
// ============================================================================
module bit_serial_comparator
  import serial_cmp_pkg::*;
(
  input  wire logic clk,
  input  wire logic rst,
  input  wire logic clr,
  input  wire logic en,
  input  wire logic a_bit,
  input  wire logic b_bit,
  output logic      lt,
  output logic      eq,
  output logic      gt
);

  logic [1:0] r_state;

  // Comparison state: only an undecided (EQ) state can be moved by a bit pair
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= CMP_EQ;
    end else if (clr) begin
      r_state <= CMP_EQ;
    end else if (en && (r_state == CMP_EQ) && (a_bit != b_bit)) begin
      r_state <= a_bit ? CMP_GT : CMP_LT;
    end
  end

  assign lt = (r_state == CMP_LT);
  assign eq = (r_state == CMP_EQ);
  assign gt = (r_state == CMP_GT);

endmodule
`default_nettype wire

// File: rtl/serial_compare_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : serial_compare_scheduler
// Description : Round-robin arbiter for two requesters sharing one bit-serial
//               comparator. Latches the winner's operands, shifts them MSB
//               first for WIDTH edges, then pulses done with L/E/G flags.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_compare_scheduler
  import serial_cmp_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  wire logic                  clk,
  input  wire logic                  rst,
  serial_compare_scheduler_if.slave  bus
);

  localparam int              CW         = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]   c_cnt_last = CW'(WIDTH - 1);

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_sa;
  logic [WIDTH-1:0] r_sb;
  logic [CW-1:0]    r_cnt;
  logic             r_last;
  logic             r_owner;
  logic [1:0]       r_gnt;
  logic             r_busy;
  logic             r_done;
  logic             r_done_id;
  logic             r_l;
  logic             r_e;
  logic             r_g;

  logic             w_grant;
  logic             w_winner;
  logic             w_cmp_en;
  logic             w_lt;
  logic             w_eq;
  logic             w_gt;

  // Arbitration only happens in IDLE, so requests are ignored while busy
  assign w_grant  = (r_state == ST_IDLE) && (bus.req != 2'b00);
  assign w_winner = rr_pick(bus.req, r_last);
  assign w_cmp_en = (r_state == ST_SHIFT);

  // The grant edge also clears the comparator back to EQ
  bit_serial_comparator u_cmp (
    .clk   (clk),
    .rst   (rst),
    .clr   (w_grant),
    .en    (w_cmp_en),
    .a_bit (r_sa[WIDTH-1]),
    .b_bit (r_sb[WIDTH-1]),
    .lt    (w_lt),
    .eq    (w_eq),
    .gt    (w_gt)
  );

  // Scheduler FSM: grant/latch in IDLE, WIDTH shift edges, then publish the
  // result on the edge leaving DONE so the comparator has settled by then.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_sa      <= '0;
      r_sb      <= '0;
      r_cnt     <= '0;
      r_last    <= 1'b1;
      r_owner   <= 1'b0;
      r_gnt     <= 2'b00;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_done_id <= 1'b0;
      r_l       <= 1'b0;
      r_e       <= 1'b0;
      r_g       <= 1'b0;
    end else begin
      r_gnt  <= 2'b00;
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_grant) begin
            r_gnt   <= w_winner ? 2'b10 : 2'b01;
            r_sa    <= w_winner ? bus.a1 : bus.a0;
            r_sb    <= w_winner ? bus.b1 : bus.b0;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_owner <= w_winner;
            r_state <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          r_sa  <= r_sa << 1;
          r_sb  <= r_sb << 1;
          r_cnt <= r_cnt + CW'(1);
          if (r_cnt == c_cnt_last) begin
            r_state <= ST_DONE;
          end
        end
        ST_DONE: begin
          r_l       <= w_lt;
          r_e       <= w_eq;
          r_g       <= w_gt;
          r_done    <= 1'b1;
          r_done_id <= r_owner;
          r_last    <= r_owner;
          r_busy    <= 1'b0;
          r_state   <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.gnt     = r_gnt;
  assign bus.busy    = r_busy;
  assign bus.done    = r_done;
  assign bus.done_id = r_done_id;
  assign bus.L       = r_l;
  assign bus.E       = r_e;
  assign bus.G       = r_g;

endmodule
`default_nettype wire
